// File: rtl/seq_tx_pkg.sv
// Shared definitions for the serial pattern transmitter.
// Holds the state encoding and the default widths used by seq_pattern_tx.
package seq_tx_pkg;

    localparam int PAT_W_DEF = 4;
    localparam int REP_W_DEF = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_PAR   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        PAR   = ST_PAR,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/seq_tx_piso.sv
// Parallel-in serial-out shift register; load wins over shift.
// Shifts left, presenting the MSB on o_msb.
module seq_tx_piso #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_data,
    output logic         o_msb
);

    logic [W-1:0] r_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr <= '0;
        end else if (i_load) begin
            r_sr <= i_data;
        end else if (i_shift) begin
            r_sr <= {r_sr[W-2:0], 1'b0};
        end
    end

    assign o_msb = r_sr[W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Repeating serial pattern transmitter with abort and done pulse.
// Define SEQ_TX_PARITY_EN to append an even-parity bit after each pattern.
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int REP_W = REP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [REP_W-1:0] rep,
    input  logic             abort,
    output logic             x,
    output logic             x_vld,
    output logic             busy,
    output logic             done
);

    localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [BW-1:0] BIT_MAX = BW'(PAT_W - 1);

    state_t           r_state;
    state_t           w_nxt;
    logic [BW-1:0]    r_bit;
    logic [BW-1:0]    w_bit_nxt;
    logic [REP_W-1:0] r_rep;
    logic [REP_W-1:0] w_rep_nxt;
    logic [PAT_W-1:0] r_pat;
    logic             r_x;
    logic             r_vld;
    logic             r_busy;
    logic             r_done;

    logic             w_lat;
    logic             w_load;
    logic             w_shift;
    logic [PAT_W-1:0] w_ld_val;
    logic             w_msb;
    logic             w_eop;
    logic             w_nxt_x;
    logic             w_nxt_vld;
    logic             w_nxt_busy;
    logic             w_nxt_done;
`ifdef SEQ_TX_PARITY_EN
    logic             w_par;

    assign w_par = ^r_pat;
`endif

    // Shifter holds only the bits still to be sent; r_x carries the current one.
    seq_tx_piso #(
        .W (PAT_W)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (w_ld_val),
        .o_msb   (w_msb)
    );

    always_comb begin
        w_nxt      = r_state;
        w_bit_nxt  = r_bit;
        w_rep_nxt  = r_rep;
        w_lat      = 1'b0;
        w_load     = 1'b0;
        w_shift    = 1'b0;
        w_ld_val   = '0;
        w_eop      = 1'b0;
        w_nxt_x    = 1'b0;
        w_nxt_vld  = 1'b0;
        w_nxt_busy = 1'b0;
        w_nxt_done = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_lat = 1'b1;
                    if (rep == '0) begin
                        w_nxt      = DONE;
                        w_nxt_done = 1'b1;
                    end else begin
                        w_nxt      = SHIFT;
                        w_load     = 1'b1;
                        w_ld_val   = {pattern[PAT_W-2:0], 1'b0};
                        w_nxt_x    = pattern[PAT_W-1];
                        w_nxt_vld  = 1'b1;
                        w_nxt_busy = 1'b1;
                        w_bit_nxt  = BIT_MAX;
                        w_rep_nxt  = rep;
                    end
                end
            end
            SHIFT: begin
                if (abort) begin
                    w_nxt     = IDLE;
                    w_load    = 1'b1;
                    w_bit_nxt = '0;
                    w_rep_nxt = '0;
                end else if (r_bit != '0) begin
                    w_shift    = 1'b1;
                    w_nxt_x    = w_msb;
                    w_nxt_vld  = 1'b1;
                    w_nxt_busy = 1'b1;
                    w_bit_nxt  = r_bit - 1'b1;
                end else begin
`ifdef SEQ_TX_PARITY_EN
                    w_nxt      = PAR;
                    w_nxt_x    = w_par;
                    w_nxt_vld  = 1'b1;
                    w_nxt_busy = 1'b1;
`else
                    w_eop = 1'b1;
`endif
                end
            end
            PAR: begin
                if (abort) begin
                    w_nxt     = IDLE;
                    w_load    = 1'b1;
                    w_bit_nxt = '0;
                    w_rep_nxt = '0;
                end else begin
                    w_eop = 1'b1;
                end
            end
            DONE: begin
                w_nxt = IDLE;
            end
        endcase

        // End of one repetition: reload from the latched copy or finish.
        if (w_eop) begin
            w_rep_nxt = r_rep - 1'b1;
            w_load    = 1'b1;
            if (r_rep <= 1) begin
                w_nxt      = DONE;
                w_nxt_done = 1'b1;
                w_bit_nxt  = '0;
            end else begin
                w_nxt      = SHIFT;
                w_ld_val   = {r_pat[PAT_W-2:0], 1'b0};
                w_nxt_x    = r_pat[PAT_W-1];
                w_nxt_vld  = 1'b1;
                w_nxt_busy = 1'b1;
                w_bit_nxt  = BIT_MAX;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_bit   <= '0;
            r_rep   <= '0;
            r_pat   <= '0;
            r_x     <= 1'b0;
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_bit   <= w_bit_nxt;
            r_rep   <= w_rep_nxt;
            r_x     <= w_nxt_x;
            r_vld   <= w_nxt_vld;
            r_busy  <= w_nxt_busy;
            r_done  <= w_nxt_done;
            if (w_lat) begin
                r_pat <= pattern;
            end
        end
    end

    assign x     = r_x;
    assign x_vld = r_vld;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: expected {x,x_vld,busy,done} per cycle.
// Compile with SEQ_TX_PARITY_EN to exercise the parity build.
module tb_seq_pattern_tx;

    typedef logic [3:0] obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] pattern;
    logic [3:0] rep;
    logic       abort;
    logic       x;
    logic       x_vld;
    logic       busy;
    logic       done;

    obs_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    seq_pattern_tx dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pattern (pattern),
        .rep     (rep),
        .abort   (abort),
        .x       (x),
        .x_vld   (x_vld),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Model of the output stream after an accepted start, one entry per cycle.
    task automatic push_model(input logic [3:0] p, input logic [3:0] r);
        for (int k = 0; k < int'(r); k++) begin
            for (int b = 3; b >= 0; b--) q.push_back({p[b], 3'b110});
`ifdef SEQ_TX_PARITY_EN
            q.push_back({^p, 3'b110});
`endif
        end
        q.push_back(4'b0001);
        q.push_back(4'b0000);
    endtask

    // Start at edge k; returns at the negedge inside cycle k+1 with inputs scrambled.
    task automatic drive_start(input logic [3:0] p, input logic [3:0] r);
        @(negedge clk);
        pattern = p;
        rep     = r;
        start   = 1'b1;
        push_model(p, r);
        @(negedge clk);
        start   = 1'b0;
        pattern = ~p;
        rep     = r + 4'd1;
    endtask

    task automatic test_reset;
        obs_t e;
        rst = 1'b1; start = 1'b1; abort = 1'b0;
        pattern = 4'b1010; rep = 4'd1;
        #3;
        n_vec++;
        if ({x, x_vld, busy, done} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_t0: got %b want 0000", {x, x_vld, busy, done});
        end
        @(negedge clk);
        n_vec++;
        if ({x, x_vld, busy, done} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_held: got %b want 0000", {x, x_vld, busy, done});
        end
        push_model(4'b1010, 4'd1);
        rst = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (q.size() > 0) begin
            e = q.pop_front(); n_vec++;
            if ({x, x_vld, busy, done} !== e) begin
                n_err++;
                $display("FAIL first_start: got %b want %b", {x, x_vld, busy, done}, e);
            end
            if (q.size() > 0) @(negedge clk);
        end
    endtask

    task automatic test_single;
        obs_t e;
        drive_start(4'b1010, 4'd1);
        while (q.size() > 0) begin
            e = q.pop_front(); n_vec++;
            if ({x, x_vld, busy, done} !== e) begin
                n_err++;
                $display("FAIL single: got %b want %b", {x, x_vld, busy, done}, e);
            end
            if (q.size() > 0) @(negedge clk);
        end
    endtask

    task automatic test_repeat;
        obs_t e;
        drive_start(4'b1010, 4'd3);
        while (q.size() > 0) begin
            e = q.pop_front(); n_vec++;
            if ({x, x_vld, busy, done} !== e) begin
                n_err++;
                $display("FAIL repeat3: got %b want %b", {x, x_vld, busy, done}, e);
            end
            if (q.size() > 0) @(negedge clk);
        end
        drive_start(4'b0111, 4'd2);
        while (q.size() > 0) begin
            e = q.pop_front(); n_vec++;
            if ({x, x_vld, busy, done} !== e) begin
                n_err++;
                $display("FAIL repeat_0111: got %b want %b", {x, x_vld, busy, done}, e);
            end
            if (q.size() > 0) @(negedge clk);
        end
    endtask

    task automatic test_max_rep;
        obs_t e;
        drive_start(4'b0110, 4'd15);
        while (q.size() > 0) begin
            e = q.pop_front(); n_vec++;
            if ({x, x_vld, busy, done} !== e) begin
                n_err++;
                $display("FAIL max_rep: got %b want %b", {x, x_vld, busy, done}, e);
            end
            if (q.size() > 0) @(negedge clk);
        end
    endtask

    task automatic test_abort;
        obs_t e;
        drive_start(4'b1010, 4'd3);
        for (int i = 0; i < 5; i++) begin
            e = q.pop_front(); n_vec++;
            if ({x, x_vld, busy, done} !== e) begin
                n_err++;
                $display("FAIL abort_pre%0d: got %b want %b", i, {x, x_vld, busy, done}, e);
            end
            if (i < 4) @(negedge clk);
        end
        abort = 1'b1;
        q.delete();
        repeat (3) q.push_back(4'b0000);
        @(negedge clk);
        abort = 1'b0;
        while (q.size() > 0) begin
            e = q.pop_front(); n_vec++;
            if ({x, x_vld, busy, done} !== e) begin
                n_err++;
                $display("FAIL abort_post: got %b want %b", {x, x_vld, busy, done}, e);
            end
            if (q.size() > 0) @(negedge clk);
        end
        drive_start(4'b1100, 4'd1);
        while (q.size() > 0) begin
            e = q.pop_front(); n_vec++;
            if ({x, x_vld, busy, done} !== e) begin
                n_err++;
                $display("FAIL abort_restart: got %b want %b", {x, x_vld, busy, done}, e);
            end
            if (q.size() > 0) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        obs_t e;
        @(negedge clk);
        pattern = 4'b0110; rep = 4'd2; start = 1'b1;
        push_model(4'b0110, 4'd2);
        @(negedge clk);
        pattern = 4'b1111; rep = 4'd5;
        while (q.size() > 0) begin
            e = q.pop_front(); n_vec++;
            if ({x, x_vld, busy, done} !== e) begin
                n_err++;
                $display("FAIL start_held: got %b want %b", {x, x_vld, busy, done}, e);
            end
            if (q.size() > 0) @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);
        pattern = 4'b1111; rep = 4'd0; start = 1'b1; abort = 1'b1;
        push_model(4'b1111, 4'd0);
        @(negedge clk);
        start = 1'b0;
        while (q.size() > 0) begin
            e = q.pop_front(); n_vec++;
            if ({x, x_vld, busy, done} !== e) begin
                n_err++;
                $display("FAIL rep0: got %b want %b", {x, x_vld, busy, done}, e);
            end
            if (q.size() > 0) @(negedge clk);
        end
        abort = 1'b0;
        @(negedge clk);
        pattern = 4'b1001; rep = 4'd2; start = 1'b1; abort = 1'b1;
        push_model(4'b1001, 4'd2);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        while (q.size() > 0) begin
            e = q.pop_front(); n_vec++;
            if ({x, x_vld, busy, done} !== e) begin
                n_err++;
                $display("FAIL start_abort: got %b want %b", {x, x_vld, busy, done}, e);
            end
            if (q.size() > 0) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        obs_t e;
        drive_start(4'b1010, 4'd3);
        for (int i = 0; i < 3; i++) begin
            e = q.pop_front(); n_vec++;
            if ({x, x_vld, busy, done} !== e) begin
                n_err++;
                $display("FAIL rst_pre%0d: got %b want %b", i, {x, x_vld, busy, done}, e);
            end
            if (i < 2) @(negedge clk);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({x, x_vld, busy, done} !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_async: got %b want 0000", {x, x_vld, busy, done});
        end
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        drive_start(4'b0011, 4'd1);
        while (q.size() > 0) begin
            e = q.pop_front(); n_vec++;
            if ({x, x_vld, busy, done} !== e) begin
                n_err++;
                $display("FAIL rst_restart: got %b want %b", {x, x_vld, busy, done}, e);
            end
            if (q.size() > 0) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat();
        test_abort();
        test_back_to_back();
        test_max_rep();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
